// File: rtl/midi_msg_decoder_if.sv
// rtl/midi_msg_decoder_if.sv - raw MIDI byte input and decoded message output bus
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_NONE
`define MIDI_CMD_NONE 4'd0
`endif
`ifndef MIDI_CMD_NOTE_OFF
`define MIDI_CMD_NOTE_OFF 4'd1
`endif
`ifndef MIDI_CMD_NOTE_ON
`define MIDI_CMD_NOTE_ON 4'd2
`endif
`ifndef MIDI_CMD_AFTERTOUCH
`define MIDI_CMD_AFTERTOUCH 4'd3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'd4
`endif
`ifndef MIDI_CMD_PATCH_CHG
`define MIDI_CMD_PATCH_CHG 4'd5
`endif
`ifndef MIDI_CMD_CH_PRESSURE
`define MIDI_CMD_CH_PRESSURE 4'd6
`endif
`ifndef MIDI_CMD_PITCH_BEND
`define MIDI_CMD_PITCH_BEND 4'd7
`endif

interface midi_msg_decoder_if;
    logic                      data_in_rdy;
    logic [7:0]                data_in;
    logic                      midi_rdy;
    logic [`MIDI_CMD_SIZE-1:0] midi_cmd;
    logic [3:0]                midi_ch_sysn;
    logic [6:0]                midi_data0;
    logic [6:0]                midi_data1;
    logic                      msg_err;

    modport master (
        output data_in_rdy, data_in,
        input  midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1, msg_err
    );

    modport slave (
        input  data_in_rdy, data_in,
        output midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1, msg_err
    );
endinterface

// File: rtl/midi_msg_decoder.sv
// rtl/midi_msg_decoder.sv - MIDI byte stream to channel-voice message decoder
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_NONE
`define MIDI_CMD_NONE 4'd0
`endif
`ifndef MIDI_CMD_NOTE_OFF
`define MIDI_CMD_NOTE_OFF 4'd1
`endif
`ifndef MIDI_CMD_NOTE_ON
`define MIDI_CMD_NOTE_ON 4'd2
`endif
`ifndef MIDI_CMD_AFTERTOUCH
`define MIDI_CMD_AFTERTOUCH 4'd3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'd4
`endif
`ifndef MIDI_CMD_PATCH_CHG
`define MIDI_CMD_PATCH_CHG 4'd5
`endif
`ifndef MIDI_CMD_CH_PRESSURE
`define MIDI_CMD_CH_PRESSURE 4'd6
`endif
`ifndef MIDI_CMD_PITCH_BEND
`define MIDI_CMD_PITCH_BEND 4'd7
`endif

module midi_msg_decoder #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input logic               clk,
    input logic               reset,
    midi_msg_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_WAIT_STATUS,
        ST_DATA0,
        ST_DATA1,
        ST_DISCARD
    } state_t;

    state_t                    state, state_n;
    logic                      rs_valid, rs_valid_n;
    logic [`MIDI_CMD_SIZE-1:0] rs_cmd, rs_cmd_n;
    logic [3:0]                rs_ch, rs_ch_n;
    logic [6:0]                d0_q, d0_n;
    logic [15:0]               tmo_cnt, tmo_cnt_n;
    logic                      emit, err;
    logic [`MIDI_CMD_SIZE-1:0] out_cmd;
    logic [6:0]                out_d0, out_d1;
    logic                      is_rt, byte_ev, in_msg;

    function automatic logic [`MIDI_CMD_SIZE-1:0] cmd_of(input logic [2:0] hi);
        case (hi)
            3'd0:    cmd_of = `MIDI_CMD_NOTE_OFF;
            3'd1:    cmd_of = `MIDI_CMD_NOTE_ON;
            3'd2:    cmd_of = `MIDI_CMD_AFTERTOUCH;
            3'd3:    cmd_of = `MIDI_CMD_CC;
            3'd4:    cmd_of = `MIDI_CMD_PATCH_CHG;
            3'd5:    cmd_of = `MIDI_CMD_CH_PRESSURE;
            default: cmd_of = `MIDI_CMD_PITCH_BEND;
        endcase
    endfunction

    function automatic logic one_data(input logic [`MIDI_CMD_SIZE-1:0] c);
        one_data = (c == `MIDI_CMD_PATCH_CHG) || (c == `MIDI_CMD_CH_PRESSURE);
    endfunction

    // Real-time bytes are invisible: they neither advance nor clear anything.
    assign is_rt   = bus.data_in_rdy && (bus.data_in >= 8'hF8);
    assign byte_ev = bus.data_in_rdy && !is_rt;
    assign in_msg  = (state == ST_DATA0) || (state == ST_DATA1);

    always_comb begin
        state_n    = state;
        rs_valid_n = rs_valid;
        rs_cmd_n   = rs_cmd;
        rs_ch_n    = rs_ch;
        d0_n       = d0_q;
        tmo_cnt_n  = tmo_cnt;
        emit       = 1'b0;
        err        = 1'b0;
        out_cmd    = rs_cmd;
        out_d0     = d0_q;
        out_d1     = 7'd0;
        if (byte_ev) begin
            tmo_cnt_n = 16'd0;
            if (bus.data_in[7]) begin
                err = in_msg;
                if (bus.data_in[7:4] == 4'hF) begin
                    rs_valid_n = 1'b0;
                    state_n    = (bus.data_in == 8'hF7) ? ST_WAIT_STATUS : ST_DISCARD;
                end else begin
                    rs_valid_n = 1'b1;
                    rs_cmd_n   = cmd_of(bus.data_in[6:4]);
                    rs_ch_n    = bus.data_in[3:0];
                    state_n    = ST_DATA0;
                end
            end else begin
                case (state)
                    ST_WAIT_STATUS, ST_DATA0: begin
                        if (rs_valid) begin
                            d0_n = bus.data_in[6:0];
                            if (one_data(rs_cmd)) begin
                                emit    = 1'b1;
                                out_d0  = bus.data_in[6:0];
                                state_n = ST_WAIT_STATUS;
                            end else begin
                                state_n = ST_DATA1;
                            end
                        end
                    end
                    ST_DATA1: begin
                        emit    = 1'b1;
                        out_d1  = bus.data_in[6:0];
                        state_n = ST_WAIT_STATUS;
                        if (rs_cmd == `MIDI_CMD_NOTE_ON && bus.data_in[6:0] == 7'd0)
                            out_cmd = `MIDI_CMD_NOTE_OFF;
                    end
                    default: ;
                endcase
            end
        end else if (!is_rt && in_msg && TIMEOUT_CYCLES != 16'd0) begin
            if (tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
                err       = 1'b1;
                state_n   = ST_WAIT_STATUS;
                tmo_cnt_n = 16'd0;
            end else begin
                tmo_cnt_n = tmo_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_WAIT_STATUS;
            rs_valid         <= 1'b0;
            rs_cmd           <= `MIDI_CMD_NONE;
            rs_ch            <= 4'd0;
            d0_q             <= 7'd0;
            tmo_cnt          <= 16'd0;
            bus.midi_rdy     <= 1'b0;
            bus.msg_err      <= 1'b0;
            bus.midi_cmd     <= `MIDI_CMD_NONE;
            bus.midi_ch_sysn <= 4'd0;
            bus.midi_data0   <= 7'd0;
            bus.midi_data1   <= 7'd0;
        end else begin
            state        <= state_n;
            rs_valid     <= rs_valid_n;
            rs_cmd       <= rs_cmd_n;
            rs_ch        <= rs_ch_n;
            d0_q         <= d0_n;
            tmo_cnt      <= tmo_cnt_n;
            bus.midi_rdy <= emit;
            bus.msg_err  <= err;
            if (emit) begin
                bus.midi_cmd     <= out_cmd;
                bus.midi_ch_sysn <= rs_ch;
                bus.midi_data0   <= out_d0;
                bus.midi_data1   <= out_d1;
            end
        end
    end
endmodule

// File: tb/tb_midi_msg_decoder.sv
// tb/tb_midi_msg_decoder.sv - self-checking bench for midi_msg_decoder
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif

module tb_midi_msg_decoder;
    localparam int TMO = 100;
    localparam logic [3:0] C_NOTE_OFF = 4'd1, C_NOTE_ON = 4'd2, C_AT = 4'd3, C_CC = 4'd4,
                           C_PATCH = 4'd5, C_PRESS = 4'd6, C_BEND = 4'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    midi_msg_decoder_if bus ();

    midi_msg_decoder #(.TIMEOUT_CYCLES(16'(TMO))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [21:0] pack(input logic [3:0] c, input logic [3:0] ch,
                                         input logic [6:0] d0, input logic [6:0] d1);
        pack = {c, ch, d0, d1};
    endfunction

    // Byte-level reference: a message is a status plus the number of data
    // bytes its command needs; anything that breaks that shape is an error.
    logic [7:0] m_rs;
    bit         m_in;
    logic [6:0] m_buf[$];
    int         m_idle;
    logic       e_rdy, e_err;
    logic [3:0] e_cmd, e_ch;
    logic [6:0] e_d0, e_d1;

    function automatic int need(input logic [7:0] s);
        need = (s[7:4] == 4'hC || s[7:4] == 4'hD) ? 1 : 2;
    endfunction

    function automatic logic [3:0] code(input logic [7:0] s, input logic [6:0] d1);
        case (s[7:4])
            4'h8: code = C_NOTE_OFF;
            4'h9: code = (d1 == 7'd0) ? C_NOTE_OFF : C_NOTE_ON;
            4'hA: code = C_AT;
            4'hB: code = C_CC;
            4'hC: code = C_PATCH;
            4'hD: code = C_PRESS;
            default: code = C_BEND;
        endcase
    endfunction

    task automatic model_step();
        if (reset) begin
            m_rs = 8'h00; m_in = 0; m_buf.delete(); m_idle = 0;
            e_rdy = 0; e_err = 0; e_cmd = 0; e_ch = 0; e_d0 = 0; e_d1 = 0;
            return;
        end
        e_rdy = 0;
        e_err = 0;
        if (bus.data_in_rdy && bus.data_in >= 8'hF8) begin
        end else if (bus.data_in_rdy) begin
            m_idle = 0;
            if (bus.data_in[7]) begin
                if (m_in) e_err = 1;
                m_in = 0;
                m_buf.delete();
                if (bus.data_in >= 8'hF0) m_rs = 8'h00;
                else begin
                    m_rs = bus.data_in;
                    m_in = 1;
                end
            end else if (m_rs != 8'h00) begin
                m_buf.push_back(bus.data_in[6:0]);
                m_in = 1;
                if (m_buf.size() == need(m_rs)) begin
                    e_d0  = m_buf[0];
                    e_d1  = (need(m_rs) == 2) ? m_buf[1] : 7'd0;
                    e_cmd = code(m_rs, e_d1);
                    e_ch  = m_rs[3:0];
                    e_rdy = 1;
                    m_in  = 0;
                    m_buf.delete();
                end
            end
        end else if (m_in) begin
            m_idle++;
            if (m_idle == TMO) begin
                e_err = 1;
                m_in = 0;
                m_buf.delete();
                m_idle = 0;
            end
        end
    endtask

    always @(posedge clk or posedge reset) model_step();

    logic [21:0] caps[$];
    int          n_err_seen = 0;

    always @(negedge clk) begin
        check("cycle", {8'h0, bus.midi_rdy, bus.msg_err, bus.midi_cmd, bus.midi_ch_sysn,
                        bus.midi_data0, bus.midi_data1},
                       {8'h0, e_rdy, e_err, e_cmd, e_ch, e_d0, e_d1});
        if (!reset && bus.midi_rdy)
            caps.push_back(pack(bus.midi_cmd, bus.midi_ch_sysn, bus.midi_data0, bus.midi_data1));
        if (!reset && bus.msg_err) n_err_seen++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.data_in_rdy = 1'b1;
        bus.data_in     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.data_in_rdy = 1'b0;
            bus.data_in     = 8'h00;
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    int base_m, base_e;

    initial begin
        bus.data_in_rdy = 1'b0;
        bus.data_in     = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {8'h0, bus.midi_rdy, bus.msg_err, bus.midi_cmd, bus.midi_ch_sysn,
                                bus.midi_data0, bus.midi_data1}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Basic note-on with one-cycle latency
        base_m = caps.size(); base_e = n_err_seen;
        send_seq('{8'h90, 8'h3C, 8'h64});
        idle(1); #1;
        check("t1_rdy_latency", 32'(bus.midi_rdy), 32'd1);
        idle(1); #1;
        check("t1_rdy_single", 32'(bus.midi_rdy), 32'd0);
        idle(2); #1;
        check("t1_count", caps.size() - base_m, 1);
        check("t1_msg", 32'(caps[base_m]), 32'(pack(C_NOTE_ON, 4'd0, 7'h3C, 7'h64)));

        // Running status and velocity-0
        base_m = caps.size();
        send_seq('{8'h93, 8'h40, 8'h7F, 8'h40, 8'h00});
        idle(3); #1;
        check("t2_count", caps.size() - base_m, 2);
        check("t2_msg0", 32'(caps[base_m]), 32'(pack(C_NOTE_ON, 4'd3, 7'h40, 7'h7F)));
        check("t2_msg1", 32'(caps[base_m+1]), 32'(pack(C_NOTE_OFF, 4'd3, 7'h40, 7'h00)));

        // Real-time bytes interleaved
        base_m = caps.size();
        send_seq('{8'hB1, 8'hF8, 8'h07, 8'hFE, 8'h55});
        idle(3); #1;
        check("t3_count", caps.size() - base_m, 1);
        check("t3_msg", 32'(caps[base_m]), 32'(pack(C_CC, 4'd1, 7'h07, 7'h55)));

        // Program change, SysEx discard, orphan data byte
        base_m = caps.size();
        send_seq('{8'hC5, 8'h12, 8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h20});
        idle(3); #1;
        check("t4_count", caps.size() - base_m, 1);
        check("t4_msg", 32'(caps[base_m]), 32'(pack(C_PATCH, 4'd5, 7'h12, 7'h00)));
        check("t1_t4_no_err", n_err_seen - base_e, 0);

        // Status interrupting a message
        base_m = caps.size(); base_e = n_err_seen;
        send_seq('{8'h80, 8'h3C, 8'h90, 8'h3C, 8'h50});
        idle(3); #1;
        check("t5_err", n_err_seen - base_e, 1);
        check("t5_count", caps.size() - base_m, 1);
        check("t5_msg", 32'(caps[base_m]), 32'(pack(C_NOTE_ON, 4'd0, 7'h3C, 7'h50)));

        // Timeout after exactly TMO idle cycles, running status kept
        base_m = caps.size(); base_e = n_err_seen;
        send_seq('{8'hE0, 8'h00});
        idle(TMO); #1;
        check("t6_no_early_err", n_err_seen - base_e, 0);
        idle(2); #1;
        check("t6_err", n_err_seen - base_e, 1);
        send_seq('{8'h00, 8'h40});
        idle(3); #1;
        check("t6_count", caps.size() - base_m, 1);
        check("t6_msg", 32'(caps[base_m]), 32'(pack(C_BEND, 4'd0, 7'h00, 7'h40)));

        // One-data running status and aftertouch
        base_m = caps.size();
        send_seq('{8'hD2, 8'h33, 8'h44, 8'hA4, 8'h10, 8'h20});
        idle(3); #1;
        check("t7_count", caps.size() - base_m, 3);
        check("t7_msg0", 32'(caps[base_m]), 32'(pack(C_PRESS, 4'd2, 7'h33, 7'h00)));
        check("t7_msg1", 32'(caps[base_m+1]), 32'(pack(C_PRESS, 4'd2, 7'h44, 7'h00)));
        check("t7_msg2", 32'(caps[base_m+2]), 32'(pack(C_AT, 4'd4, 7'h10, 7'h20)));

        // Reset mid-message
        base_m = caps.size();
        send(8'h90);
        idle(1);
        #1 reset = 1'b1;
        #1;
        check("t8_reset_outputs", {8'h0, bus.midi_rdy, bus.msg_err, bus.midi_cmd, bus.midi_ch_sysn,
                                   bus.midi_data0, bus.midi_data1}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        send_seq('{8'h3C, 8'h50});
        idle(5); #1;
        check("t8_no_emit", caps.size() - base_m, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
